// File: rtl/hazard_control_unit.sv
// Hazard controller: load-use stall, taken-branch flush, blocking MD unit sequencing (optional stall counter via HAZ_STALL_COUNT_EN).
// Latency: control outputs are combinational from state, mdCnt and current inputs; state advances on core clock edge.
// Backpressure: front end stalls one cycle per load-use hazard and MD_CYCLES cycles per multiply/divide op.
module hazard_control_unit #(
    parameter int REG_W     = 4,
    parameter int MD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IDreadReg1,
    input  logic [REG_W-1:0] IDreadReg2,
    input  logic             IDmdOp,
    input  logic             IEmemRead,
    input  logic [REG_W-1:0] IEwriteReg,
    input  logic             branchTaken,
    output logic             pcWrite,
    output logic             IFIDwrite,
    output logic             IFIDflush,
    output logic             IDIEbubble,
    output logic             mdStart,
    output logic             mdBusy,
    output logic             mdDone
`ifdef HAZ_STALL_COUNT_EN
    ,
    output logic [15:0]      stallCount
`endif
);

    localparam int CNT_W = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             load_haz;

    assign load_haz = IEmemRead && (IEwriteReg != '0) &&
                      ((IEwriteReg == IDreadReg1) || (IEwriteReg == IDreadReg2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // MD_BUSY never looks at the inputs, so unknown operands there cannot leak into state.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (!branchTaken && !load_haz && IDmdOp) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d  = RUN;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pcWrite    = 1'b1;
        IFIDwrite  = 1'b1;
        IFIDflush  = 1'b0;
        IDIEbubble = 1'b0;
        mdStart    = 1'b0;
        mdBusy     = 1'b0;
        mdDone     = 1'b0;
        if (!rst_n) begin
            // Pipeline frozen while reset is held, independent of the clock.
            pcWrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDIEbubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (branchTaken) begin
                        IFIDflush  = 1'b1;
                        IDIEbubble = 1'b1;
                    end else if (load_haz) begin
                        pcWrite    = 1'b0;
                        IFIDwrite  = 1'b0;
                        IDIEbubble = 1'b1;
                    end else if (IDmdOp) begin
                        mdStart = 1'b1;
                    end
                end
                MD_BUSY: begin
                    pcWrite    = 1'b0;
                    IFIDwrite  = 1'b0;
                    IDIEbubble = 1'b1;
                    mdBusy     = 1'b1;
                    mdDone     = (md_cnt_q == '0);
                end
                default: begin
                    pcWrite    = 1'b0;
                    IFIDwrite  = 1'b0;
                    IDIEbubble = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZ_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
`endif

endmodule
